// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO, configurable data width, parity and stop bits.
// Queued words are sent back-to-back; serial_out, busy and tx_done are registered.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 20,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [DATA_BITS-1:0]          in_data,
  output logic                          in_ready,
  output logic                          serial_out,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [CW-1:0] BAUD_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_PENULT = CW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST   = 1'(STOP_BITS - 1);
  localparam logic [AW:0]   DEPTH       = (AW + 1)'(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic [2:0]           state;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] sh;
  logic [DATA_BITS-1:0] head;
  logic                 par;
  logic                 head_par;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic                 frame_end;

  always_comb begin
    full      = (fifo_count == DEPTH);
    empty     = (fifo_count == '0);
    in_ready  = !full && !reset;
    push      = in_valid && in_ready;
    head      = mem[rd_ptr[AW-1:0]];
    head_par  = (PARITY == 1) ? ~^head : ^head;
    bit_end   = (baud_cnt == BAUD_LAST);
    frame_end = (state == S_STOP) && bit_end && (stop_idx == STOP_LAST);
    pop       = !empty && ((state == S_IDLE) || frame_end);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        fifo_count <= fifo_count + 1'b1;
      else if (pop && !push)
        fifo_count <= fifo_count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  // serial_out is registered, so each transition loads the level of the slot being entered;
  // data bits are taken from sh[0]/sh[1] with sh shifting right instead of indexing by bit_idx.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      sh         <= '0;
      par        <= 1'b0;
      serial_out <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        S_IDLE: begin
          serial_out <= 1'b1;
          busy       <= 1'b0;
          baud_cnt   <= '0;
          if (pop) begin
            sh         <= head;
            par        <= head_par;
            state      <= S_START;
            serial_out <= 1'b0;
            busy       <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            baud_cnt   <= '0;
            bit_idx    <= '0;
            state      <= S_DATA;
            serial_out <= sh[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              if (PARITY != 0) begin
                state      <= S_PARITY;
                serial_out <= par;
              end else begin
                state      <= S_STOP;
                stop_idx   <= 1'b0;
                serial_out <= 1'b1;
              end
            end else begin
              bit_idx    <= bit_idx + 1'b1;
              serial_out <= sh[1];
              sh         <= sh >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            baud_cnt   <= '0;
            state      <= S_STOP;
            stop_idx   <= 1'b0;
            serial_out <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          tx_done <= (stop_idx == STOP_LAST) && (baud_cnt == BAUD_PENULT);
          if (bit_end) begin
            baud_cnt <= '0;
            if (stop_idx != STOP_LAST) begin
              stop_idx <= 1'b1;
            end else if (pop) begin
              sh         <= head;
              par        <= head_par;
              state      <= S_START;
              serial_out <= 1'b0;
            end else begin
              state      <= S_IDLE;
              busy       <= 1'b0;
              serial_out <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          serial_out <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
